// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus: default widths, master IDs
// and the lock state encoding used by the port arbiter.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Master identifiers as they appear in grant indices and owner tags
    localparam logic MASTER_CPU    = 1'b0;
    localparam logic MASTER_LOADER = 1'b1;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_lock_grant.sv
// Two-way round-robin grant with a bounded lock. Holds the last-granted
// master, the lock state/owner and the consecutive-locked-grant counter.
// The grant vector is combinational on req and forced low during reset.
module rr_lock_grant
    import mem_bus_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam logic [7:0] CNT_MAX = 8'(LOCK_MAX);

    logic        last_q, last_d;
    lock_state_e state_q, state_d;
    logic        lock_owner_q, lock_owner_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;

    logic [1:0]  gnt_raw;
    logic        gnt_id;
    logic        forced;

    // Grant rule: a live lock wins unless its burst is spent and the other master waits
    always_comb begin
        gnt_raw = 2'b00;
        forced  = 1'b0;
        if (state_q == LOCK_LOCKED && req[lock_owner_q]) begin
            if (lock_cnt_q == CNT_MAX && req[~lock_owner_q]) begin
                forced               = 1'b1;
                gnt_raw[~lock_owner_q] = 1'b1;
            end else begin
                gnt_raw[lock_owner_q] = 1'b1;
            end
        end else if (req == 2'b01) begin
            gnt_raw = 2'b01;
        end else if (req == 2'b10) begin
            gnt_raw = 2'b10;
        end else if (req == 2'b11) begin
            gnt_raw = last_q ? 2'b01 : 2'b10;
        end
    end

    assign gnt_id = gnt_raw[1];
    assign gnt    = rst ? gnt_raw : 2'b00;

    // Next-state for round-robin pointer and lock bookkeeping
    always_comb begin
        last_d       = last_q;
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (gnt_raw != 2'b00) begin
            last_d = gnt_id;
            if (forced) begin
                state_d    = LOCK_UNLOCKED;
                lock_cnt_d = 8'd0;
            end else if (state_q == LOCK_LOCKED && gnt_id == lock_owner_q) begin
                if (lock[gnt_id]) begin
                    if (lock_cnt_q != CNT_MAX) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end else begin
                    state_d    = LOCK_UNLOCKED;
                    lock_cnt_d = 8'd0;
                end
            end else if (lock[gnt_id]) begin
                state_d      = LOCK_LOCKED;
                lock_owner_d = gnt_id;
                lock_cnt_d   = 8'd1;
            end else begin
                state_d    = LOCK_UNLOCKED;
                lock_cnt_d = 8'd0;
            end
        end else if (state_q == LOCK_LOCKED && !req[lock_owner_q]) begin
            state_d    = LOCK_UNLOCKED;
            lock_cnt_d = 8'd0;
        end
    end

    // Arbiter state registers; last starts at 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q       <= 1'b1;
            state_q      <= LOCK_UNLOCKED;
            lock_owner_q <= MASTER_CPU;
            lock_cnt_q   <= 8'd0;
        end else begin
            last_q       <= last_d;
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single DMem port between the CPU load/store path (master 0)
// and the program/debug loader (master 1). Muxes the granted request onto
// the memory port and steers the one-cycle-late read data to its issuer.
module dmem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    logic [1:0] gnt;
    logic       gnt_any;
    logic       sel_we;

    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;
    logic owner_q, owner_d;

    rr_lock_grant #(
        .LOCK_MAX (LOCK_MAX)
    ) u_grant (
        .clk  (clk),
        .rst  (rst),
        .req  ({m1_req, m0_req}),
        .lock ({m1_lock, m0_lock}),
        .gnt  (gnt)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign gnt_any = |gnt;

    // Memory port mux: master 0 payload by default, strobes only on a grant
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        sel_we    = m0_we;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (gnt[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            sel_we    = m1_we;
        end
        if (gnt_any) begin
            mem_we = sel_we;
            mem_re = ~sel_we;
        end
    end

    // Read tracking: remember which master's read is in flight this cycle
    always_comb begin
        rd_pend_d  = gnt_any & ~sel_we;
        rd_owner_d = gnt_any ? gnt[1] : rd_owner_q;
        owner_d    = gnt_any ? gnt[1] : owner_q;
    end

    // Read-tag and owner registers; reset drops any in-flight read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= MASTER_CPU;
            owner_q    <= MASTER_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            owner_q    <= owner_d;
        end
    end

    assign owner     = owner_q;
    assign m0_rvalid = rd_pend_q && (rd_owner_q == MASTER_CPU);
    assign m1_rvalid = rd_pend_q && (rd_owner_q == MASTER_LOADER);
    assign m0_rdata  = (rd_owner_q == MASTER_CPU)    ? mem_rdata : '0;
    assign m1_rdata  = (rd_owner_q == MASTER_LOADER) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a vector table for single-cycle
// behaviour plus hand-written lock, reset and saturation sequences.
module tb_dmem_port_arbiter;
    import mem_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner;

    int total;
    int bad;

    dmem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LOCK_MAX (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DMem: synchronous write, one-cycle registered read
    logic [31:0] mem [0:255];
    initial begin
        mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[8'h10] = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic [1:0]  exp_gnt;
        logic        exp_re, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [1:0]  exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic [1:0] g, input logic re, input logic we,
        input logic [31:0] ea, input logic [31:0] ed,
        input logic [1:0] rv, input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = 1'b0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = 1'b0; v.a1 = a1; v.d1 = d1;
        v.exp_gnt = g; v.exp_re = re; v.exp_we = we;
        v.exp_addr = ea; v.exp_wdata = ed;
        v.exp_rvalid = rv; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic r0, input logic w0, input logic l0,
                                  input logic [31:0] a0, input logic [31:0] d0,
                                  input logic r1, input logic w1, input logic l1,
                                  input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        apply_idle();

        // Vector table: reset-release read, alternating reads, write/read conflict
        vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0, 2'b01,1,0,32'h10,0, 2'b00,0));
        vecs.push_back(mk(0,0,32'h00,0, 0,0,0,0, 2'b00,0,0,32'h00,0, 2'b01,32'hDEAD_BEEF));
        vecs.push_back(mk(0,0,32'h00,0, 1,0,32'h30,0, 2'b10,1,0,32'h30,0, 2'b00,0));
        vecs.push_back(mk(1,0,32'h40,0, 1,0,32'h50,0, 2'b01,1,0,32'h40,0, 2'b10,32'hA000_0030));
        vecs.push_back(mk(1,0,32'h40,0, 1,0,32'h50,0, 2'b10,1,0,32'h50,0, 2'b01,32'hA000_0040));
        vecs.push_back(mk(1,0,32'h40,0, 1,0,32'h50,0, 2'b01,1,0,32'h40,0, 2'b10,32'hA000_0050));
        vecs.push_back(mk(1,0,32'h40,0, 1,0,32'h50,0, 2'b10,1,0,32'h50,0, 2'b01,32'hA000_0040));
        vecs.push_back(mk(0,0,32'h00,0, 0,0,0,0, 2'b00,0,0,32'h00,0, 2'b10,32'hA000_0050));
        vecs.push_back(mk(1,1,32'h20,32'h55, 1,0,32'h20,0, 2'b01,0,1,32'h20,32'h55, 2'b00,0));
        vecs.push_back(mk(0,0,32'h00,0, 1,0,32'h20,0, 2'b10,1,0,32'h20,0, 2'b00,0));
        vecs.push_back(mk(0,0,32'h00,0, 0,0,0,0, 2'b00,0,0,32'h00,0, 2'b10,32'h55));

        // Reset values, with a request present to show grants are held off
        @(negedge clk);
        m0_req = 1'b1;
        #2;
        check_output("reset_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
        check_output("reset_strobe", {30'b0, mem_we, mem_re}, 32'h0);
        check_output("reset_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        check_output("reset_owner", {31'b0, owner}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
                           vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1);
            #2;
            check_output($sformatf("v%0d_gnt", i), {30'b0, m1_gnt, m0_gnt}, {30'b0, vecs[i].exp_gnt});
            check_output($sformatf("v%0d_strobe", i), {30'b0, mem_we, mem_re},
                         {30'b0, vecs[i].exp_we, vecs[i].exp_re});
            check_output($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_we)
                check_output($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
            check_output($sformatf("v%0d_rvalid", i), {30'b0, m1_rvalid, m0_rvalid},
                         {30'b0, vecs[i].exp_rvalid});
            if (vecs[i].exp_rvalid[0])
                check_output($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_rvalid[1])
                check_output($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].exp_rdata);
            @(negedge clk);
        end

        // Lock burst: m1 locks alone, then m0 joins; m1 keeps 8 grants, m0 gets the 9th
        for (int c = 1; c <= 9; c++) begin
            apply_stimulus(c > 1, 1'b1, 1'b0, 32'h61, 32'h1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h2);
            #2;
            check_output($sformatf("lock_burst_c%0d", c), {30'b0, m1_gnt, m0_gnt},
                         (c <= 8) ? 32'h2 : 32'h1);
            @(negedge clk);
        end
        check_output("lock_burst_released", 32'(dut.u_grant.state_q), 32'(LOCK_UNLOCKED));
        apply_idle();
        @(negedge clk);

        // Reset arriving in the cycle after a granted m1 read drops the read
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h70, 32'h0);
        #2;
        check_output("rst_rd_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("rst_rd_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        check_output("rst_rd_gnt_held", {30'b0, m1_gnt, m0_gnt}, 32'h0);
        check_output("rst_rd_strobe", {30'b0, mem_we, mem_re}, 32'h0);
        check_output("rst_rd_owner", {31'b0, owner}, 32'h0);
        apply_idle();
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_output("rst_rd_never", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        @(negedge clk);

        // Saturation: m0 locked with m1 idle for 20 cycles, then m1 breaks in at once
        for (int c = 1; c <= 20; c++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            #2;
            check_output($sformatf("sat_c%0d", c), {30'b0, m1_gnt, m0_gnt}, 32'h1);
            @(negedge clk);
        end
        check_output("sat_cnt", 32'(dut.u_grant.lock_cnt_q), 32'd8);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'h3, 1'b1, 1'b0, 1'b0, 32'h81, 32'h0);
        #2;
        check_output("sat_break_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h2);
        check_output("sat_break_addr", mem_addr, 32'h81);
        @(negedge clk);
        check_output("sat_break_unlocked", 32'(dut.u_grant.state_q), 32'(LOCK_UNLOCKED));
        apply_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

- Shares the single data-memory port between two requesters:
  - master 0: the CPU load/store path (MemOrIO side).
  - master 1: the program/debug loader that writes test data into data memory before and between runs.
- Sits between those requesters and `DMem`.
- Arbitration is round-robin on contention. A lock lets a master keep the port for a bounded burst.
- Read data returns to the master that issued the read, one cycle later.

## Interface
Parameters:
- ADDR_W, 32, address width of both masters and the memory port
- DATA_W, 32, data width
- LOCK_MAX, 8, maximum consecutive locked grants before a forced release; legal range 2..255

Ports:
- clk  in  1  CPU clock (cpu_clk domain)
- rst  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  access request; held until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_lock, m1_lock  in  1  request to keep the port after this grant
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  read data valid (registered)
- m0_rdata, m1_rdata  out  DATA_W  read data; value is don't-care when rvalid = 0
- mem_re, mem_we  out  1  memory strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re
- owner  out  1  master granted in the last granted cycle

## Operation
- State registers:
  - last (1b)
  - locked (1b)
  - lock_owner (1b)
  - lock_cnt (8b)
  - rd_pend (1b)
  - rd_owner (1b)
- Grant rule, evaluated every cycle. At most one gnt is high.
  - locked = 1 and lock_owner requesting → grant lock_owner.
  - locked = 1, lock_owner idle → clear locked; arbitrate normally in the same cycle.
  - Only one master requesting → grant it.
  - Both requesting → grant ~last (round-robin).
- Memory drive on a granted cycle:
  - mem_addr and mem_wdata come from the granted master.
  - mem_we = we; mem_re = ~we.
- Memory drive with no grant: mem_re = mem_we = 0; mem_addr and mem_wdata hold the master-0 values.
- Updates on a granted cycle:
  - last ← granted master.
  - If it was a read: rd_pend ← 1, rd_owner ← granted master. Otherwise rd_pend ← 0.
- Updates on a non-granted cycle: rd_pend ← 0.
- Read return:
  - mx_rvalid = rd_pend && rd_owner == x.
  - mx_rdata = mem_rdata routed to rd_owner.
- Lock state machine, with states UNLOCKED and LOCKED:
  - UNLOCKED → LOCKED when a grant coincides with that master's lock = 1. Set lock_cnt = 1.
  - LOCKED, same master granted with lock = 1 → lock_cnt + 1.
  - LOCKED, granted with lock = 0 → UNLOCKED.
  - lock_cnt == LOCK_MAX and the other master is requesting → forced release:
    - the other master is granted that cycle; state → UNLOCKED.
  - lock_cnt saturates at LOCK_MAX while the other master is idle.
- Write and read in the same cycle from different masters cannot both proceed. The loser stalls (gnt = 0) and keeps req and its payload stable.

## Timing
- gnt: same cycle as req (combinational through the grant rule).
- Write latency: written on the rising edge ending the gnt cycle.
- Read latency: exactly 1 cycle. rvalid and rdata appear in the cycle after gnt.
- Back-to-back reads from alternating masters: one per cycle, each rvalid tagged to its issuer.
- Reset (rst = 0, asynchronous):
  - all gnt, rvalid, mem_re, mem_we = 0
  - last = 1, so master 0 wins the first tie
  - locked = 0, lock_cnt = 0, rd_pend = 0, owner = 0
- Reset mid-read: the pending rvalid is dropped and never delivered.
- Deassertion of req without a gnt is a master protocol violation. The arbiter does not check it.

## Structure
- Shared package `mem_bus_pkg`:
  - ADDR_W and DATA_W defaults
  - master-ID constants (CPU = 0, LOADER = 1)
  - lock state enum
- One sub-module, `rr_lock_grant`:
  - contains the grant rule plus the last, locked and lock_cnt registers
  - outputs the 2-bit grant vector
- The top level contains:
  - the memory mux
  - rd_pend/rd_owner tracking
  - the read-data routing

## Test plan
- Reset release, only m0_req reading addr 0x10 with mem_rdata = 0xDEADBEEF:
  - m0_gnt = 1 in the same cycle, mem_re = 1, mem_addr = 0x10
  - m0_rvalid = 1 with 0xDEADBEEF next cycle; m1_rvalid = 0
- Both masters request reads continuously:
  - grants alternate 0, 1, 0, 1 starting with master 0
  - each rvalid arrives on the issuer's port one cycle after its gnt
- m1 holds lock = 1 with m0 requesting, LOCK_MAX = 8:
  - m1 is granted for 8 cycles
  - m0 is granted in the 9th cycle; lock state → UNLOCKED
- m0 write 0x55 to 0x20 while m1 reads 0x20, both requesting in cycle 0:
  - m0 is granted first (write)
  - m1 is granted in cycle 1 and reads 0x55
- rst asserted in the cycle after a granted m1 read: m1_rvalid stays 0; all outputs show their reset values.
- m0 lock = 1 with m1 idle for 20 cycles:
  - m0 is granted every cycle; lock_cnt saturates at 8
  - when m1_req rises, m1 is granted in that same cycle
